// File: rtl/parking_pkg.sv
// ============================================================================
// parking_pkg: shared types, default sizing and width helper for the
// parking gate controller.  Rev 1.0
// ============================================================================
`default_nettype none

package parking_pkg;

  typedef enum logic [0:0] {
    GATE_IDLE = 1'b0,
    GATE_OPEN = 1'b1
  } gate_state_t;

  localparam int DEF_NGATES   = 2;
  localparam int DEF_CAPACITY = 16;
  localparam int DEF_TIMEOUT  = 1000;

  // Bits needed to hold max_val, never less than one.
  function automatic int width_of(input int max_val);
    width_of = (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/parking_gate_fsm.sv
// ============================================================================
// parking_gate_fsm: one barrier arm, raised on grant, lowered on enter or
// timeout; flags an enter seen while the arm is down.  Rev 1.0
// ============================================================================
`default_nettype none

module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic grant,
  input  logic enter,
  output logic arm_up,
  output logic open,
  output logic tailgate
);

  localparam int TW = width_of(TIMEOUT - 1);

  localparam logic [0:0] ST_IDLE = GATE_IDLE;
  localparam logic [0:0] ST_OPEN = GATE_OPEN;

  logic [0:0]    state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      timer    <= '0;
      tailgate <= 1'b0;
    end else begin
      tailgate <= enter && (state == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state <= ST_OPEN;
            timer <= TW'(TIMEOUT - 1);
          end
        end
        default: begin
          // Timer reaching zero means the arm has been up for TIMEOUT cycles.
          if (enter || (timer == '0)) begin
            state <= ST_IDLE;
            timer <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
      endcase
    end
  end

  assign open   = (state == ST_OPEN);
  assign arm_up = open;

endmodule

`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
// ============================================================================
// parking_gate_ctrl: round-robin admission across gates with capacity
// reservation, per-gate arm FSMs and a clamped occupancy counter.  Rev 1.0
// ============================================================================
`default_nettype none

module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int NGATES   = DEF_NGATES,
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  localparam int CW      = $clog2(CAPACITY + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NGATES-1:0] req,
  input  logic [NGATES-1:0] enter,
  input  logic [NGATES-1:0] exit,
  output logic [NGATES-1:0] arm_up,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              err_tailgate,
  output logic              err_range
);

  localparam int PW = width_of(NGATES - 1);
  localparam int GW = width_of(NGATES);
  localparam int SW = ((CW > GW) ? CW : GW) + 2;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  logic [NGATES-1:0] open_vec;
  logic [NGATES-1:0] tg_vec;
  logic [NGATES-1:0] eligible;
  logic [NGATES-1:0] grant_vec;
  logic [GW-1:0]     reserved;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     winner;
  logic [PW-1:0]     cand;
  logic              found;
  logic              room;
  int                idx;

  logic signed [SW-1:0] n_enter;
  logic signed [SW-1:0] n_exit;
  logic signed [SW-1:0] next_sum;
  logic [CW-1:0]        count_nxt;
  logic                 clamp;

  for (genvar g = 0; g < NGATES; g++) begin : g_gate
    parking_gate_fsm #(
      .TIMEOUT (TIMEOUT)
    ) u_fsm (
      .clk      (clk),
      .reset    (reset),
      .grant    (grant_vec[g]),
      .enter    (enter[g]),
      .arm_up   (arm_up[g]),
      .open     (open_vec[g]),
      .tailgate (tg_vec[g])
    );
  end

  always_comb begin
    reserved = '0;
    n_enter  = '0;
    n_exit   = '0;
    for (int g = 0; g < NGATES; g++) begin
      reserved = reserved + GW'(open_vec[g]);
      n_enter  = n_enter + SW'(enter[g]);
      n_exit   = n_exit + SW'(exit[g]);
    end
  end

  assign eligible = req & ~open_vec;
  // Open arms hold a space so a car already waiting under a raised arm is never locked out.
  assign room = ({{(SW-CW){1'b0}}, count} + SW'(reserved)) < SW'(CAPACITY);

  always_comb begin
    found     = 1'b0;
    winner    = '0;
    cand      = '0;
    idx       = 0;
    grant_vec = '0;
    for (int i = 0; i < NGATES; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NGATES) idx = idx - NGATES;
      cand = PW'(idx);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    if (found && room) grant_vec[winner] = 1'b1;
  end

  always_comb begin
    next_sum  = $signed({{(SW-CW){1'b0}}, count}) + n_enter - n_exit;
    count_nxt = next_sum[CW-1:0];
    clamp     = 1'b0;
    if (next_sum[SW-1]) begin
      count_nxt = '0;
      clamp     = 1'b1;
    end else if (next_sum > CAP_S) begin
      count_nxt = CW'(CAPACITY);
      clamp     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      count     <= '0;
      err_range <= 1'b0;
    end else begin
      count     <= count_nxt;
      err_range <= clamp;
      if (|grant_vec) begin
        ptr <= (winner == PW'(NGATES - 1)) ? '0 : winner + PW'(1);
      end
    end
  end

  assign err_tailgate = |tg_vec;
  assign full         = (count == CW'(CAPACITY));
  assign empty        = (count == '0);

endmodule

`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
// ============================================================================
// tb_parking_gate_ctrl: directed vector table plus hand sequences for
// timeout and mid-operation reset.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_parking_gate_ctrl;

  localparam int NG  = 2;
  localparam int CAP = 2;
  localparam int TO  = 8;
  localparam int CW  = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [NG-1:0] req, enter, exit;
  logic [NG-1:0] arm_up;
  logic [CW-1:0] count;
  logic          full, empty, err_tailgate, err_range;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  parking_gate_ctrl #(
    .NGATES   (NG),
    .CAPACITY (CAP),
    .TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .enter        (enter),
    .exit         (exit),
    .arm_up       (arm_up),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .err_tailgate (err_tailgate),
    .err_range    (err_range)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] enter;
    logic [1:0] exit;
    logic [1:0] arm;
    int         cnt;
    logic       tg;
    logic       rng;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic [1:0] r, input logic [1:0] e, input logic [1:0] x,
                              input logic [1:0] a, input int c, input logic t, input logic g);
    vec_t v;
    v.req = r; v.enter = e; v.exit = x; v.arm = a; v.cnt = c; v.tg = t; v.rng = g;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] ea, input int ec,
                       input logic et, input logic er);
    logic ok;
    ok = (arm_up === ea) && (count === CW'(ec)) && (full === (ec == CAP)) &&
         (empty === (ec == 0)) && (err_tailgate === et) && (err_range === er);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got arm=%b count=%0d full=%b empty=%b tg=%b rng=%b; expected arm=%b count=%0d full=%b empty=%b tg=%b rng=%b",
               name, arm_up, count, full, empty, err_tailgate, err_range,
               ea, ec, (ec == CAP), (ec == 0), et, er);
    end
  endtask

  initial begin
    // req, enter, exit -> arm, count, tailgate, range
    tbl[0]  = mk(2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 0);
    tbl[1]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 1, 0, 0);
    tbl[2]  = mk(2'b11, 2'b00, 2'b00, 2'b10, 1, 0, 0);
    tbl[3]  = mk(2'b11, 2'b00, 2'b00, 2'b10, 1, 0, 0);
    tbl[4]  = mk(2'b11, 2'b00, 2'b01, 2'b10, 0, 0, 0);
    tbl[5]  = mk(2'b11, 2'b00, 2'b00, 2'b11, 0, 0, 0);
    tbl[6]  = mk(2'b00, 2'b10, 2'b00, 2'b01, 1, 0, 0);
    tbl[7]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 2, 0, 0);
    tbl[8]  = mk(2'b00, 2'b11, 2'b00, 2'b00, 2, 1, 1);
    tbl[9]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2, 0, 0);
    tbl[10] = mk(2'b00, 2'b01, 2'b10, 2'b00, 2, 1, 0);
    tbl[11] = mk(2'b11, 2'b00, 2'b00, 2'b00, 2, 0, 0);
    tbl[12] = mk(2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0);
    tbl[13] = mk(2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 1);
    tbl[14] = mk(2'b10, 2'b00, 2'b00, 2'b10, 0, 0, 0);
    tbl[15] = mk(2'b00, 2'b10, 2'b00, 2'b00, 1, 0, 0);
    tbl[16] = mk(2'b00, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    tbl[17] = mk(2'b11, 2'b00, 2'b00, 2'b01, 0, 0, 0);
    tbl[18] = mk(2'b11, 2'b00, 2'b00, 2'b11, 0, 0, 0);
    tbl[19] = mk(2'b11, 2'b00, 2'b00, 2'b11, 0, 0, 0);
    tbl[20] = mk(2'b00, 2'b11, 2'b00, 2'b00, 2, 0, 0);
    tbl[21] = mk(2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0);
    tbl[22] = mk(2'b11, 2'b00, 2'b00, 2'b01, 0, 0, 0);
    tbl[23] = mk(2'b00, 2'b01, 2'b00, 2'b00, 1, 0, 0);

    reset = 1'b0;
    req   = '0;
    enter = '0;
    exit  = '0;
    tick();
    tick();
    check("reset_state", 2'b00, 0, 1'b0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      req   = tbl[i].req;
      enter = tbl[i].enter;
      exit  = tbl[i].exit;
      tick();
      check($sformatf("row%0d", i), tbl[i].arm, tbl[i].cnt, tbl[i].tg, tbl[i].rng);
    end
    req = '0; enter = '0; exit = '0;

    // Timeout: count=1, only gate0 requests; arm stays up exactly TO cycles.
    req = 2'b01;
    tick();
    check("timeout_grant", 2'b01, 1, 1'b0, 1'b0);
    req = 2'b00;
    for (int k = 1; k <= TO; k++) begin
      tick();
      check($sformatf("timeout_k%0d", k), (k < TO) ? 2'b01 : 2'b00, 1, 1'b0, 1'b0);
    end
    enter = 2'b01;
    tick();
    check("late_enter_tailgate", 2'b00, 2, 1'b1, 1'b0);
    enter = 2'b00;
    tick();
    check("tailgate_clears", 2'b00, 2, 1'b0, 1'b0);

    // Mid-operation reset with an arm raised and count=1.
    exit = 2'b01;
    tick();
    check("exit_to_one", 2'b00, 1, 1'b0, 1'b0);
    exit = 2'b00;
    req  = 2'b01;
    tick();
    check("open_before_reset", 2'b01, 1, 1'b0, 1'b0);
    req = 2'b00;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_immediate", 2'b00, 0, 1'b0, 1'b0);
    req   = 2'b11;
    enter = 2'b01;
    tick();
    check("reset_hold_1", 2'b00, 0, 1'b0, 1'b0);
    tick();
    check("reset_hold_2", 2'b00, 0, 1'b0, 1'b0);
    enter = 2'b00;
    reset = 1'b1;
    tick();
    check("post_reset_ptr0", 2'b01, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
